fib_bcd_converter: RTL and testbench
====================================

// Module: fib_bcd_converter
// PURPOSE
//  Downstream stage of the Fibonacci engine. Captures the 16-bit result when the
//  engine's done rises, converts it to packed BCD using a sequential double-dabble
//  (one bit per clock), and presents the digits on a valid/ready output for the
//  display/UART stage that follows.
// PARAMETERS
//  WIDTH   16  binary input width; equals the engine dout width
//  DIGITS  5   BCD digits out; must satisfy 10**DIGITS > 2**WIDTH-1 (not checked in RTL)
// PORTS
//  clk        in   1         rising-edge clock
//  reset_n    in   1         asynchronous active-low reset
//  fib_dout   in   WIDTH     engine result; sampled only on the capture edge
//  fib_done   in   1         engine done level; may stay high for many cycles
//  bcd_out    out  4*DIGITS  packed BCD, digit 0 (ones) in [3:0]
//  out_valid  out  1         bcd_out valid; held until accepted
//  out_ready  in   1         consumer accepts when out_valid && out_ready
//  busy       out  1         high in SHIFT or HOLD
//  overrun    out  1         1-cycle pulse: capture event dropped because not IDLE
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE, bcd_out=0, out_valid=0, busy=0, overrun=0,
//   done_q=0, shift regs=0, bit counter=0. Deassertion is used without synchronisation.
//  Capture event: fib_done && !done_q, where done_q is fib_done registered each clock.
//   A done level held high gives exactly one event; re-arms only after done goes low.
//  FSM IDLE -> SHIFT -> HOLD -> IDLE:
//   IDLE:  on capture event, load bin_sr<=fib_dout, bcd_sr<=0, cnt<=0, go SHIFT.
//   SHIFT: each clock, first add 3 to every bcd_sr digit >=5, then shift
//          {bcd_sr,bin_sr} left by 1 (bin MSB enters bcd bit 0), cnt++.
//          On the clock where cnt==WIDTH-1: bcd_out<=result of that iteration,
//          out_valid<=1, go HOLD.
//   HOLD:  out_valid=1, bcd_out stable. When out_ready=1, next edge sets out_valid<=0
//          and goes IDLE. bcd_out keeps its last value after the handshake.
//  Latency: capture at edge E0. out_valid first seen high after edge E0+WIDTH
//   (17 clocks for WIDTH=16). Back-to-back, no stall: 1 more clock for the handshake,
//   then IDLE accepts the next event on the following edge.
//  Overrun: a capture event while in SHIFT or HOLD, including the HOLD cycle in which
//   the handshake completes, is discarded. overrun=1 for exactly the next cycle.
//   The conversion in progress is unaffected.
//  busy = (state != IDLE), registered along with the state.
//  Width rules: digits are 4-bit. The add-3 is applied per digit before the shift,
//   so no digit exceeds 9 after the shift. cnt is $clog2(WIDTH)+1 bits and never wraps.
//  Reset mid-operation: everything returns to reset values immediately and the
//   partial result is lost. A done still high after reset release is seen as a new
//   edge (done_q=0), so it is captured once.
//  fib_dout changing outside the capture edge has no effect.
// TESTING
//  1 done rises with dout=0 -> 17 clks later out_valid=1, bcd_out=20'h00000; ready=1 clears it next clk
//  2 dout=55, 46368, 65535 (separate runs) -> bcd_out=20'h00055 / 20'h46368 / 20'h65535
//  3 dout=6765, out_ready low 5 clks in HOLD -> out_valid and bcd_out=20'h06765 stable
//    all 5 clks; drops 1 clk after ready=1
//  4 done held high 40 clks with dout=89 -> exactly one conversion, no overrun;
//    done low then high again -> second conversion
//  5 second done edge 4 clks into SHIFT -> overrun pulses 1 clk; first result
//    unchanged; no second out_valid
//  6 reset_n low at SHIFT cnt=8 -> outputs 0 immediately, state IDLE; new done edge
//    after release -> correct result

Source files
------------

// File: rtl/fib_bcd_converter_if.sv
// Handshake bundle between the Fibonacci engine, the BCD converter and the display stage.
// The slave modport is the converter's view; master is the surrounding environment.
interface fib_bcd_converter_if #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DIGITS = 5
);
    logic [WIDTH-1:0]    fib_dout;
    logic                fib_done;
    logic [4*DIGITS-1:0] bcd_out;
    logic                out_valid;
    logic                out_ready;
    logic                busy;
    logic                overrun;

    modport master (
        output fib_dout, fib_done, out_ready,
        input  bcd_out, out_valid, busy, overrun
    );

    modport slave (
        input  fib_dout, fib_done, out_ready,
        output bcd_out, out_valid, busy, overrun
    );
endinterface

// File: rtl/fib_bcd_converter.sv
// Captures the engine result on the rising edge of done and converts it to packed BCD
// with a one-bit-per-clock double-dabble, presenting the digits on a valid/ready output.
module fib_bcd_converter #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DIGITS = 5
) (
    input logic                   clk,
    input logic                   reset_n,
    fib_bcd_converter_if.slave    bus
);
    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        HOLD
    } state_t;

    state_t              state_q, state_d;
    logic                done_q, done_d;
    logic [WIDTH-1:0]    bin_sr_q, bin_sr_d;
    logic [4*DIGITS-1:0] bcd_sr_q, bcd_sr_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [4*DIGITS-1:0] bcd_out_q, bcd_out_d;
    logic                out_valid_q, out_valid_d;
    logic                busy_q, busy_d;
    logic                overrun_q, overrun_d;

    logic                capture;
    logic [4*DIGITS-1:0] bcd_adj;
    logic [4*DIGITS-1:0] bcd_next;
    logic [WIDTH-1:0]    bin_next;

    assign capture = bus.fib_done && !done_q;

    // Add-3 correction on every digit, then the combined register shifts left by one.
    always_comb begin
        bcd_adj = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bcd_sr_q[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_sr_q[4*i +: 4] + 4'd3;
            else
                bcd_adj[4*i +: 4] = bcd_sr_q[4*i +: 4];
        end
        bcd_next = {bcd_adj[4*DIGITS-2:0], bin_sr_q[WIDTH-1]};
        bin_next = {bin_sr_q[WIDTH-2:0], 1'b0};
    end

    always_comb begin
        state_d     = state_q;
        done_d      = bus.fib_done;
        bin_sr_d    = bin_sr_q;
        bcd_sr_d    = bcd_sr_q;
        cnt_d       = cnt_q;
        bcd_out_d   = bcd_out_q;
        out_valid_d = out_valid_q;
        overrun_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (capture) begin
                    bin_sr_d = bus.fib_dout;
                    bcd_sr_d = '0;
                    cnt_d    = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                overrun_d = capture;
                bin_sr_d  = bin_next;
                bcd_sr_d  = bcd_next;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    bcd_out_d   = bcd_next;
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                // A capture event coinciding with the handshake is still dropped.
                overrun_d = capture;
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            done_q      <= 1'b0;
            bin_sr_q    <= '0;
            bcd_sr_q    <= '0;
            cnt_q       <= '0;
            bcd_out_q   <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            done_q      <= done_d;
            bin_sr_q    <= bin_sr_d;
            bcd_sr_q    <= bcd_sr_d;
            cnt_q       <= cnt_d;
            bcd_out_q   <= bcd_out_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.bcd_out   = bcd_out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_fib_bcd_converter.sv
// Scoreboard bench for fib_bcd_converter: stimulus pushes hand-computed BCD results,
// a negedge monitor pops and compares them at every accepted output.
module tb_fib_bcd_converter;
    localparam int unsigned WIDTH  = 16;
    localparam int unsigned DIGITS = 5;

    logic clk;
    logic reset_n;

    fib_bcd_converter_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

    fib_bcd_converter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;
    int ovr_cnt = 0;
    logic [4*DIGITS-1:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: an output is consumed on the edge following a negedge where valid && ready.
    always @(negedge clk) begin
        if (reset_n && bus.overrun) ovr_cnt++;
        if (reset_n && bus.out_valid && bus.out_ready) begin
            hs_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_output", 32'(bus.bcd_out), 32'hFFFF_FFFF);
            end else begin
                chk("bcd_out", 32'(bus.bcd_out), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "global timeout");
    end

    task automatic start(input logic [WIDTH-1:0] dout, input logic [4*DIGITS-1:0] exp);
        @(negedge clk);
        bus.fib_dout = dout;
        bus.fib_done = 1'b1;
        exp_q.push_back(exp);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (n < 60) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.out_valid) break;
        end
        if (!bus.out_valid) chk("valid_timeout", 32'(bus.out_valid), 32'd1);
    endtask

    task automatic handshake(input int hold, input logic [4*DIGITS-1:0] exp);
        for (int k = 0; k < hold; k++) begin
            chk("hold_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_bcd", 32'(bus.bcd_out), 32'(exp));
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("valid_drop", 32'(bus.out_valid), 32'd0);
        chk("busy_idle", 32'(bus.busy), 32'd0);
        chk("bcd_kept", 32'(bus.bcd_out), 32'(exp));
    endtask

    task automatic conv(input logic [WIDTH-1:0] dout, input logic [4*DIGITS-1:0] exp, input int hold);
        int n;
        start(dout, exp);
        @(posedge clk);
        #1;
        bus.fib_done = 1'b0;
        chk("busy_shift", 32'(bus.busy), 32'd1);
        wait_valid(n);
        chk("latency", 32'(n), 32'd16);
        handshake(hold, exp);
    endtask

    initial begin
        int n, h0, o0;
        logic [4*DIGITS-1:0] dummy;
        reset_n       = 1'b0;
        bus.fib_dout  = '0;
        bus.fib_done  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_bcd", 32'(bus.bcd_out), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_overrun", 32'(bus.overrun), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Zero, then several plain values
        conv(16'd0, 20'h00000, 0);
        conv(16'd55, 20'h00055, 0);
        conv(16'd46368, 20'h46368, 0);
        conv(16'd65535, 20'h65535, 0);

        // Back-pressure: five cycles held in HOLD
        conv(16'd6765, 20'h06765, 5);

        // Done held high: one conversion only, then re-armed by a low period
        h0 = hs_cnt;
        o0 = ovr_cnt;
        bus.out_ready = 1'b1;
        start(16'd89, 20'h00089);
        repeat (40) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("held_done_conversions", 32'(hs_cnt - h0), 32'd1);
        chk("held_done_overrun", 32'(ovr_cnt - o0), 32'd0);
        chk("held_done_valid", 32'(bus.out_valid), 32'd0);
        bus.fib_done = 1'b0;
        repeat (2) @(posedge clk);
        conv(16'd89, 20'h00089, 0);
        chk("rearm_conversions", 32'(hs_cnt - h0), 32'd2);

        // Second done edge four clocks into SHIFT is dropped with an overrun pulse
        h0 = hs_cnt;
        o0 = ovr_cnt;
        start(16'd4181, 20'h04181);
        @(posedge clk);
        #1;
        bus.fib_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.fib_dout = 16'd1;
        bus.fib_done = 1'b1;
        @(posedge clk);
        #1;
        chk("overrun_pulse", 32'(bus.overrun), 32'd1);
        @(posedge clk);
        #1;
        chk("overrun_clear", 32'(bus.overrun), 32'd0);
        bus.fib_done = 1'b0;
        wait_valid(n);
        chk("overrun_bcd", 32'(bus.bcd_out), 32'h04181);
        handshake(0, 20'h04181);
        repeat (25) @(posedge clk);
        #1;
        chk("no_second_valid", 32'(bus.out_valid), 32'd0);
        chk("overrun_conversions", 32'(hs_cnt - h0), 32'd1);
        chk("overrun_count", 32'(ovr_cnt - o0), 32'd1);

        // Reset at cnt=8; done left high across reset is captured once afterwards
        start(16'd987, 20'h00987);
        @(posedge clk);
        #1;
        bus.fib_done = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        bus.fib_dout = 16'd1234;
        bus.fib_done = 1'b1;
        reset_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_bcd", 32'(bus.bcd_out), 32'd0);
        dummy = exp_q.pop_back();
        exp_q.push_back(20'h01234);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        bus.fib_done = 1'b0;
        chk("postrst_busy", 32'(bus.busy), 32'd1);
        wait_valid(n);
        chk("postrst_latency", 32'(n), 32'd16);
        handshake(0, 20'h01234);

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
